// File: rtl/psum_wr_arb.sv
// Round-robin psum write arbiter and row sequencer (start/accumulate/drain) for one PSUM bank.
// Latency: an accepted request word appears on psumaddr one cycle later; one word per cycle sustained.
// Backpressure: psumaddr_rdy low holds the output word; req_rdy drops to zero until that word drains.
// Optional watchdog: define PSUM_ARB_TIMEOUT_EN to enable the RUN timeout and sticky err flag.
module psum_wr_arb #(
  parameter int NUM_REQ         = 4,
  parameter int PSUM_ADDR_WIDTH = 4,
  parameter int PSUM_WIDTH      = 24,
  parameter int TIMEOUT_CYC     = 1023
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic [NUM_REQ-1:0]                                req_val,
  input  logic [NUM_REQ*(PSUM_ADDR_WIDTH+PSUM_WIDTH)-1:0]   req_data,
  output logic [NUM_REQ-1:0]                                req_rdy,
  input  logic [NUM_REQ-1:0]                                req_done,
  input  logic                                              PSUMARB_empty,
  output logic                                              ARBPSUM_fnh,
  output logic                                              MACPSUM_empty,
  output logic                                              psumaddr_val,
  output logic [PSUM_ADDR_WIDTH+PSUM_WIDTH-1:0]             psumaddr,
  input  logic                                              psumaddr_rdy,
  output logic                                              busy,
  output logic                                              err
);

  localparam int DW    = PSUM_ADDR_WIDTH + PSUM_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] done_q;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               gnt_vld;
  logic               accept;
  logic               row_complete;
  logic               tmo_hit;

  // Row is finished once every requester has declared done, nothing is pending and the output word has left.
  assign row_complete = (&done_q) && (req_val == '0) && !psumaddr_val;

`ifdef PSUM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // The final watchdog cycle also blocks grants, so pending unaccepted requests are dropped.
  assign tmo_hit = (state == S_RUN) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  // Watchdog: restarts on every accept and outside RUN, counts idle RUN cycles otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state != S_RUN) || accept) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Row sequencing: IDLE -> ARM -> RUN -> DRAIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)                   state_nxt = S_ARM;
      S_ARM:   if (!PSUMARB_empty)          state_nxt = S_RUN;
      S_RUN:   if (tmo_hit || row_complete) state_nxt = S_DRAIN;
      S_DRAIN: if (PSUMARB_empty)           state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  // Sticky per-requester done flags, cleared as a new row is armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      done_q <= '0;
    end else if ((state == S_ARM) || (state == S_RUN)) begin
      done_q <= done_q | req_done;
    end
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_vld && req_val[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant only in RUN and only when the output slot is free or freeing this cycle.
  assign accept = (state == S_RUN) && gnt_vld && (!psumaddr_val || psumaddr_rdy) && !tmo_hit;

  // One-hot ready to the granted requester.
  always_comb begin
    req_rdy = '0;
    if (accept) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Single-entry output register; load and drain in the same cycle keeps the stream gapless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psumaddr_val <= 1'b0;
      psumaddr     <= '0;
    end else if (accept) begin
      psumaddr_val <= 1'b1;
      psumaddr     <= req_data[int'(gnt_idx)*DW +: DW];
    end else if (psumaddr_rdy) begin
      psumaddr_val <= 1'b0;
    end
  end

  assign ARBPSUM_fnh   = (state == S_IDLE) || (state == S_DRAIN);
  assign MACPSUM_empty = ~psumaddr_val;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_psum_wr_arb.sv
// Bench for psum_wr_arb: per-requester source queues feed the DUT, expected beats are queued in grant order.
// Latency: beats are scored on the falling edge when psumaddr_val && psumaddr_rdy.
// Backpressure: psumaddr_rdy is driven per scenario; sources hold words until their req_rdy handshake.
module tb_psum_wr_arb;

  localparam int NUM_REQ = 4;
  localparam int AW      = 4;
  localparam int PW      = 24;
  localparam int DW      = AW + PW;
`ifdef PSUM_ARB_TIMEOUT_EN
  localparam int TMO     = 8;
`else
  localparam int TMO     = 1023;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [NUM_REQ-1:0]      req_val = '0;
  logic [NUM_REQ*DW-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]      req_rdy;
  logic [NUM_REQ-1:0]      req_done = '0;
  logic                    PSUMARB_empty = 1'b1;
  logic                    ARBPSUM_fnh;
  logic                    MACPSUM_empty;
  logic                    psumaddr_val;
  logic [DW-1:0]           psumaddr;
  logic                    psumaddr_rdy = 1'b1;
  logic                    busy;
  logic                    err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src_mem [NUM_REQ][16];
  int            src_wr  [NUM_REQ];
  int            src_rd  [NUM_REQ];
  logic [NUM_REQ-1:0] acc;

  psum_wr_arb #(
    .NUM_REQ(NUM_REQ), .PSUM_ADDR_WIDTH(AW), .PSUM_WIDTH(PW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy), .req_done(req_done),
    .PSUMARB_empty(PSUMARB_empty), .ARBPSUM_fnh(ARBPSUM_fnh), .MACPSUM_empty(MACPSUM_empty),
    .psumaddr_val(psumaddr_val), .psumaddr(psumaddr), .psumaddr_rdy(psumaddr_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  // Source model: retire the head word after a handshake, then present the next one.
  always begin
    @(negedge clk);
    acc = req_val & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && (src_rd[i] < src_wr[i])) src_rd[i]++;
      req_val[i] = (src_rd[i] < src_wr[i]);
      if (src_rd[i] < src_wr[i]) req_data[i*DW +: DW] = src_mem[i][src_rd[i]];
    end
  end

  // Scoreboard: every beat taken by the bank must match the next expected word.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (psumaddr_val && psumaddr_rdy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got=%h", psumaddr);
      end else begin
        e = exp_q.pop_front();
        if (psumaddr !== e) begin
          bad++;
          $display("FAIL beat_data got=%h exp=%h", psumaddr, e);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk(input logic [PW-1:0] d, input logic [AW-1:0] a);
    return {d, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_src(input int i, input logic [DW-1:0] w);
    src_mem[i][src_wr[i]] = w;
    src_wr[i]++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    exp_q.delete();
    req_done      = '0;
    start         = 1'b0;
    PSUMARB_empty = 1'b1;
    psumaddr_rdy  = 1'b1;
    rst_n         = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Pulse start, then let the bank leave idle; returns in the first RUN cycle.
  task automatic begin_row();
    start = 1'b1;
    cyc();
    start         = 1'b0;
    PSUMARB_empty = 1'b0;
    cyc();
  endtask

  task automatic wait_fnh(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (ARBPSUM_fnh) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_val(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (psumaddr_val) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    total++; if (ARBPSUM_fnh !== 1'b1)   begin bad++; $display("FAIL rst_fnh got=%b exp=1", ARBPSUM_fnh); end
    total++; if (psumaddr_val !== 1'b0)  begin bad++; $display("FAIL rst_val got=%b exp=0", psumaddr_val); end
    total++; if (psumaddr !== '0)        begin bad++; $display("FAIL rst_addr got=%h exp=0", psumaddr); end
    total++; if (MACPSUM_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", MACPSUM_empty); end
    total++; if (req_rdy !== '0)         begin bad++; $display("FAIL rst_rdy got=%b exp=0", req_rdy); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0)           begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    do_reset();
  endtask

  task automatic test_single_row();
    bit ok;
    do_reset();
    total++; if (ARBPSUM_fnh !== 1'b1) begin bad++; $display("FAIL row_fnh_idle got=%b exp=1", ARBPSUM_fnh); end
    for (int k = 1; k <= 3; k++) begin
      push_src(0, mk(24'hA00000 + PW'(k), AW'(k)));
      exp_q.push_back(mk(24'hA00000 + PW'(k), AW'(k)));
    end
    req_done = '1;
    begin_row();
    total++; if (ARBPSUM_fnh !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL row_fnh_run got=%b/%b exp=0/1", ARBPSUM_fnh, busy); end
    wait_fnh(ok);
    total++; if (!ok) begin bad++; $display("FAIL row_drain_wait got=timeout exp=fnh"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL row_beats_left got=%0d exp=0", exp_q.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL row_drain_busy got=%b exp=1", busy); end
    PSUMARB_empty = 1'b1;
    cyc();
    total++; if (busy !== 1'b0 || ARBPSUM_fnh !== 1'b1) begin bad++; $display("FAIL row_idle got=%b/%b exp=0/1", busy, ARBPSUM_fnh); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    push_src(0, mk(24'hB00000, 4'h0));
    push_src(0, mk(24'hB00004, 4'h4));
    push_src(1, mk(24'hB00001, 4'h1));
    push_src(2, mk(24'hB00002, 4'h2));
    push_src(3, mk(24'hB00003, 4'h3));
    exp_q.push_back(mk(24'hB00000, 4'h0));
    exp_q.push_back(mk(24'hB00001, 4'h1));
    exp_q.push_back(mk(24'hB00002, 4'h2));
    exp_q.push_back(mk(24'hB00003, 4'h3));
    exp_q.push_back(mk(24'hB00004, 4'h4));
    req_done = '1;
    begin_row();
    wait_val(ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_first_beat got=timeout exp=val"); end
    for (int k = 0; k < 5; k++) begin
      total++; if (psumaddr_val !== 1'b1) begin bad++; $display("FAIL rr_gapless beat%0d got=%b exp=1", k, psumaddr_val); end
      cyc();
    end
    wait_fnh(ok);
    total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL rr_complete got=%0d left exp=0", exp_q.size()); end
    PSUMARB_empty = 1'b1;
    cyc();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] w0;
    do_reset();
    w0 = mk(24'hC00001, 4'h9);
    push_src(1, w0);
    push_src(1, mk(24'hC00002, 4'hA));
    push_src(1, mk(24'hC00003, 4'hB));
    exp_q.push_back(w0);
    exp_q.push_back(mk(24'hC00002, 4'hA));
    exp_q.push_back(mk(24'hC00003, 4'hB));
    psumaddr_rdy = 1'b0;
    req_done     = '1;
    begin_row();
    wait_val(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_load got=timeout exp=val"); end
    for (int k = 0; k < 5; k++) begin
      total++; if (psumaddr !== w0 || psumaddr_val !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b exp=%h/1", psumaddr, psumaddr_val, w0); end
      total++; if (req_rdy !== '0) begin bad++; $display("FAIL bp_rdy got=%b exp=0", req_rdy); end
      cyc();
    end
    psumaddr_rdy = 1'b1;
    wait_fnh(ok);
    total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL bp_loss got=%0d left exp=0", exp_q.size()); end
    PSUMARB_empty = 1'b1;
    cyc();
  endtask

  task automatic test_done_with_val();
    bit ok;
    do_reset();
    req_done = 4'b1011;
    start = 1'b1;
    cyc();
    start = 1'b0;
    push_src(2, mk(24'h000010, 4'h7));
    exp_q.push_back(mk(24'h000010, 4'h7));
    cyc();
    req_done[2]   = 1'b1;
    PSUMARB_empty = 1'b0;
    cyc();
    wait_fnh(ok);
    total++; if (!ok) begin bad++; $display("FAIL dv_drain got=timeout exp=fnh"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dv_beat_before_drain got=%0d left exp=0", exp_q.size()); end
    PSUMARB_empty = 1'b1;
    cyc();
  endtask

  task automatic test_all_done_empty();
    do_reset();
    req_done = '1;
    begin_row();
    total++; if (ARBPSUM_fnh !== 1'b0) begin bad++; $display("FAIL ad_run got=%b exp=0", ARBPSUM_fnh); end
    cyc();
    total++; if (ARBPSUM_fnh !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ad_drain got=%b/%b exp=1/1", ARBPSUM_fnh, busy); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++; if (busy !== 1'b1 || ARBPSUM_fnh !== 1'b1) begin bad++; $display("FAIL ad_start_ignored got=%b/%b exp=1/1", busy, ARBPSUM_fnh); end
    PSUMARB_empty = 1'b1;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ad_idle got=%b exp=0", busy); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ad_no_rearm got=%b exp=0", busy); end
  endtask

  task automatic test_mid_row_reset();
    bit ok;
    do_reset();
    push_src(3, mk(24'hD00001, 4'h1));
    push_src(3, mk(24'hD00002, 4'h2));
    push_src(3, mk(24'hD00003, 4'h3));
    psumaddr_rdy = 1'b0;
    begin_row();
    wait_val(ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_load got=timeout exp=val"); end
    rst_n = 1'b0;
    cyc();
    total++; if (psumaddr_val !== 1'b0 || ARBPSUM_fnh !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mr_abort got=%b/%b/%b exp=0/1/0", psumaddr_val, ARBPSUM_fnh, busy); end
    total++; if (MACPSUM_empty !== 1'b1 || req_rdy !== '0) begin bad++; $display("FAIL mr_empty got=%b/%b exp=1/0", MACPSUM_empty, req_rdy); end
    src_wr[3] = 0;
    src_rd[3] = 0;
    exp_q.delete();
    rst_n        = 1'b1;
    psumaddr_rdy = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    total++; if (psumaddr_val !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_quiet got=%b/%b exp=0/0", psumaddr_val, busy); end
  endtask

`ifdef PSUM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    do_reset();
    begin_row();
    early = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (ARBPSUM_fnh !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
    cyc();
    total++; if (ARBPSUM_fnh !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL tmo_fire got=%b/%b exp=1/1", ARBPSUM_fnh, err); end
    PSUMARB_empty = 1'b1;
    cyc();
    total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b/%b exp=0/1", busy, err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", err); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    begin_row();
    for (int k = 0; k < 40; k++) cyc();
    total++; if (ARBPSUM_fnh !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL nt_wait got=%b/%b exp=0/0", ARBPSUM_fnh, err); end
    req_done = '1;
    cyc();
    cyc();
    total++; if (ARBPSUM_fnh !== 1'b1) begin bad++; $display("FAIL nt_drain got=%b exp=1", ARBPSUM_fnh); end
    PSUMARB_empty = 1'b1;
    cyc();
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    test_reset();
    test_single_row();
    test_round_robin();
    test_backpressure();
    test_done_with_val();
    test_all_done_empty();
    test_mid_row_reset();
`ifdef PSUM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
